// File: rtl/alu_op_sequencer.sv
// Command-queue sequencer for the external 3-bit ALU: queued {load, sel, B}
// commands run one per enabled cycle, each result chained back into acc.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_load,
  input  logic [1:0]               cmd_sel,
  input  logic [W-1:0]             cmd_b,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             acc,
  output logic                     carry,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [1:0]               alu_sel,
  input  logic [W-1:0]             alu_y,
  input  logic                     alu_cout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = W + 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          carry_q, carry_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic          push, pop;
  logic [EW-1:0] head;
  logic          head_load;
  logic [1:0]    head_sel;
  logic [W-1:0]  head_b;

  assign head      = mem_q[rd_ptr_q];
  assign head_load = head[EW-1];
  assign head_sel  = head[W+1:W];
  assign head_b    = head[W-1:0];

  assign cmd_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_RUN) && ena && (count_q != '0);

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign acc        = acc_q;
  assign carry      = carry_q;
  assign fifo_count = count_q;

  assign alu_a   = acc_q;
  assign alu_b   = (count_q != '0) ? head_b   : '0;
  assign alu_sel = (count_q != '0) ? head_sel : 2'b00;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    carry_d  = carry_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_q + CW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        // A push in the start cycle joins the run.
        if (start) state_d = ((count_q != '0) || push) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          count_d  = count_q - CW'(1);
          if (head_load) begin
            acc_d   = head_b;
            carry_d = 1'b0;
          end else begin
            acc_d   = alu_y;
            carry_d = alu_cout;
          end
          if (count_q == CW'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_load, cmd_sel, cmd_b};
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench for alu_op_sequencer with a behavioural ALU and
// a queue-based reference model of the command sequencer.
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int W     = 3;

  typedef struct packed { bit load; bit [1:0] sel; bit [2:0] b; } cmd_t;
  typedef struct packed { bit [2:0] acc; bit carry; } res_t;

  logic         clk = 1'b0;
  logic         rst, ena, cmd_valid, cmd_load, start;
  logic [1:0]   cmd_sel;
  logic [W-1:0] cmd_b;
  logic         cmd_ready, busy, done, carry, alu_cout;
  logic [W-1:0] acc, alu_a, alu_b, alu_y;
  logic [1:0]   alu_sel;
  logic [2:0]   fifo_count;

  int n_chk  = 0;
  int n_pass = 0;

  cmd_t model_q[$];
  res_t exp_op_q[$];
  res_t exp_done_q[$];
  int   model_acc   = 0;
  int   model_carry = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: returns {cout, y[2:0]} as an int.
  function automatic int alu_model(int a, int b, int sel);
    int s;
    case (sel)
      0: begin s = a + b; return ((s >= 8) ? 8 : 0) | (s % 8); end
      1: return ((a < b) ? 8 : 0) | ((a - b + 8) % 8);
      2: return a & b;
      default: return a | b;
    endcase
  endfunction

  assign {alu_cout, alu_y} = 4'(alu_model(int'(alu_a), int'(alu_b), int'(alu_sel)));

  alu_op_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_sel(cmd_sel), .cmd_b(cmd_b), .start(start),
    .busy(busy), .done(done), .acc(acc), .carry(carry),
    .fifo_count(fifo_count),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_cout(alu_cout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Monitor: compares acc/carry after every executed op and at every done pulse.
  bit pend = 1'b0;
  always @(negedge clk) begin
    res_t e;
    if (pend) begin
      if (exp_op_q.size() == 0) begin
        n_chk++;
        $display("FAIL op_unexpected: acc=%0d carry=%0d with no op expected", acc, carry);
      end else begin
        e = exp_op_q.pop_front();
        check("op_acc", 32'(acc), 32'(e.acc));
        check("op_carry", 32'(carry), 32'(e.carry));
      end
    end
    if (done === 1'b1) begin
      if (exp_done_q.size() == 0) begin
        n_chk++;
        $display("FAIL done_unexpected: done pulse with no run expected");
      end else begin
        e = exp_done_q.pop_front();
        check("done_acc", 32'(acc), 32'(e.acc));
        check("done_carry", 32'(carry), 32'(e.carry));
      end
    end
    pend = (busy === 1'b1) && (ena === 1'b1) && (rst === 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drains the model queue into expected per-op and final results.
  task automatic compute_run();
    res_t r;
    int   v;
    while (model_q.size() > 0) begin
      cmd_t c = model_q.pop_front();
      if (c.load) begin
        model_acc   = int'(c.b);
        model_carry = 0;
      end else begin
        v           = alu_model(model_acc, int'(c.b), int'(c.sel));
        model_acc   = v % 8;
        model_carry = v / 8;
      end
      r.acc = 3'(model_acc); r.carry = model_carry[0];
      exp_op_q.push_back(r);
    end
    r.acc = 3'(model_acc); r.carry = model_carry[0];
    exp_done_q.push_back(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_q.delete(); exp_op_q.delete(); exp_done_q.delete();
    model_acc = 0; model_carry = 0;
    @(negedge clk);
    check("rst_acc", 32'(acc), 0);
    check("rst_carry", 32'(carry), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_sel", 32'(alu_sel), 0);
    tick();
  endtask

  task automatic push(input cmd_t c);
    bit acc_ok = (model_q.size() < DEPTH);
    cmd_valid = 1'b1; cmd_load = c.load; cmd_sel = c.sel; cmd_b = c.b;
    @(negedge clk);
    check("push_ready", 32'(cmd_ready), 32'(acc_ok));
    tick();
    cmd_valid = 1'b0;
    if (acc_ok) model_q.push_back(c);
    @(negedge clk);
    check("push_count", 32'(fifo_count), 32'(model_q.size()));
    if (model_q.size() == 1) begin
      check("head_alu_b", 32'(alu_b), 32'(c.b));
      check("head_alu_sel", 32'(alu_sel), 32'(c.sel));
      check("head_alu_a", 32'(alu_a), 32'(model_acc));
    end
    tick();
  endtask

  // mode 0: ena high; 1: ena toggles 1,0,1..; 2: random ena.
  task automatic run(input int mode, input bit with_push, input cmd_t c);
    int n, pops = 0, busy_cyc = 0, it = 0, exp_busy;
    bit acc_ok = (model_q.size() < DEPTH);
    if (with_push && acc_ok) model_q.push_back(c);
    n = model_q.size();
    compute_run();
    start = 1'b1; ena = 1'b1;
    cmd_valid = with_push; cmd_load = c.load; cmd_sel = c.sel; cmd_b = c.b;
    if (with_push) begin
      @(negedge clk);
      check("start_push_ready", 32'(cmd_ready), 32'(acc_ok));
    end
    tick();
    start = 1'b0; cmd_valid = 1'b0;
    while (pops < n && it < 200) begin
      ena = (mode == 0) ? 1'b1 : (mode == 1) ? (it % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy) busy_cyc++;
      if (ena) pops++;
      it++;
      tick();
    end
    ena = 1'b1;
    exp_busy = (mode == 0) ? n : (mode == 1 && n > 0) ? 2 * n - 1 : it;
    check("run_timeout", 32'(pops), 32'(n));
    check("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
    @(negedge clk);
    check("done_high", 32'(done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_ready", 32'(cmd_ready), 0);
    check("done_count", 32'(fifo_count), 0);
    tick();
    @(negedge clk);
    check("idle_done", 32'(done), 0);
    check("idle_ready", 32'(cmd_ready), 1);
    tick();
  endtask

  function automatic cmd_t mk(bit load, int sel, int b);
    cmd_t c;
    c.load = load; c.sel = 2'(sel); c.b = 3'(b);
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    return mk(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
  endfunction

  initial begin
    rst = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0;
    cmd_sel = 2'b00; cmd_b = '0; start = 1'b0;
    tick();
    do_reset();

    // Load 5, add 3 -> acc 5 then 0 with carry 1.
    push(mk(1, 0, 5));
    push(mk(0, 0, 3));
    run(0, 1'b0, mk(0, 0, 0));
    check("t1_acc", 32'(acc), 0);
    check("t1_carry", 32'(carry), 1);

    // Fifth push against a full queue is refused.
    for (int i = 0; i < 5; i++) push(mk(0, i % 4, i + 1));
    check("t2_count", 32'(fifo_count), DEPTH);
    run(0, 1'b0, mk(0, 0, 0));

    // load 7, AND 3, OR 4 under toggling enable.
    push(mk(1, 0, 7));
    push(mk(0, 2, 3));
    push(mk(0, 3, 4));
    run(1, 1'b0, mk(0, 0, 0));
    check("t3_acc", 32'(acc), 7);
    check("t3_carry", 32'(carry), 0);

    // Empty start, then push-with-start of a single command.
    run(0, 1'b0, mk(0, 0, 0));
    check("t4_acc_kept", 32'(acc), 7);
    run(0, 1'b1, mk(0, 1, 2));
    check("t4_single", 32'(acc), 5);

    // Reset during the second cycle of a four-command run.
    for (int i = 0; i < 4; i++) push(mk(0, 0, 1));
    compute_run();
    start = 1'b1; ena = 1'b1;
    tick();
    start = 1'b0;
    tick();
    do_reset();

    // Back-to-back runs of three commands, wrapping the pointers.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) push(rnd_cmd());
      run(0, 1'b0, mk(0, 0, 0));
    end

    for (int r = 0; r < 20; r++) begin
      int n = int'($urandom_range(0, 5));
      for (int i = 0; i < n; i++) push(rnd_cmd());
      run(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rnd_cmd());
    end

    repeat (3) tick();
    check("op_q_drained", 32'(exp_op_q.size()), 0);
    check("done_q_drained", 32'(exp_done_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Controller that sequences the team's 3-bit ALU (alu_top_3bit) through a queued list of operations, using an internal accumulator as operand A.
- A host pushes {load, sel, B} commands into a small FIFO, then pulses start.
- The block then issues one ALU operation per enabled cycle and chains each result back into the accumulator.
- It sits between the tt_um pin wrapper and the ALU instance. The ALU stays purely combinational and external; the sel encoding is opaque to this block.

Parameters:
DEPTH, 4, command FIFO entries; power of two, 2..8
W, 3, ALU operand/accumulator width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
ena  input  1  execution enable; 0 stalls RUN with no state change
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted this cycle when high with cmd_valid
cmd_load  input  1  1 = load accumulator with cmd_b (no ALU op)
cmd_sel  input  2  ALU select for this command
cmd_b  input  W  ALU operand B / load value
start  input  1  begin executing queued commands
busy  output  1  high in RUN
done  output  1  one-cycle pulse on completion
acc  output  W  accumulator (registered)
carry  output  1  Cout of last executed ALU op (registered)
fifo_count  output  $clog2(DEPTH)+1  queued entries
alu_a  output  W  to ALU A
alu_b  output  W  to ALU B
alu_sel  output  2  to ALU sel
alu_y  input  W  from ALU Y
alu_cout  input  1  from ALU Cout

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - acc=0, carry=0; FIFO emptied (rd/wr pointers=0, fifo_count=0).
  - state=IDLE, busy=0, done=0.
  - Reset during RUN aborts the run and flushes the queue.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE).
- cmd_ready=(state==IDLE)&&(fifo_count<DEPTH); it is combinational.
  - Push on cmd_valid&&cmd_ready: the entry is written at wr_ptr, wr_ptr increments mod DEPTH, fifo_count+1.
  - cmd_valid in RUN/DONE or when full is ignored and nothing is written.
- IDLE + start:
  - If a push happens in the same cycle, it is included in the run.
  - Effective count (after that push) >0 -> RUN.
  - Effective count ==0 -> DONE, with acc/carry unchanged.
  - start in RUN/DONE is ignored.
- ALU drive (combinational, valid in every state):
  - alu_a=acc.
  - When fifo_count>0: alu_b=head.b, alu_sel=head.sel.
  - When fifo_count==0: alu_b=0, alu_sel=0.
- RUN, each cycle with ena=1: pop head (rd_ptr+1 mod DEPTH, count-1).
  - head.load=1: acc<=head.b, carry<=0.
  - head.load=0: acc<=alu_y, carry<=alu_cout. The ALU result is W bits; the carry is captured separately and never folded into acc.
  - Popping the last entry (count 1->0) -> DONE on the next edge.
- RUN with ena=0: no pop, no acc/carry change, stays in RUN.
- DONE: exactly one cycle, then unconditionally -> IDLE. cmd_ready=0 during DONE.
- Latency: N queued commands with ena held high give busy for N cycles; done is asserted on cycle N+1 after the start edge.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full is detected via fifo_count==DEPTH, so full and empty are never ambiguous.
- acc persists across runs. Only reset or a load command changes it outside ALU results.

Test Plan:
Bench ALU model for these tests: sel=00 add (Cout=bit 3), sel=01 subtract (Cout=borrow), sel=10 AND, sel=11 OR.
1. Reset, then push {load,b=5}, {add,b=3}, start with ena=1 -> busy for 2 cycles; acc=5 then 0; carry=1; done pulses 1 cycle; fifo_count=0.
2. Push 4 commands, then a 5th with cmd_valid=1 -> cmd_ready=0 on the 5th; fifo_count=4; only 4 ops execute after start.
3. Run {load 7},{AND 3},{OR 4} with ena toggling 1,0,1,0,1 -> acc 7,3,7 updates only on ena=1 cycles; busy stays high for 5 cycles; final acc=7, carry=0.
4. start with an empty FIFO -> done=1 next cycle, busy never asserted, acc unchanged. Push and start in the same cycle -> that single command executes.
5. Assert rst in the 2nd cycle of a 4-command run -> next cycle acc=0, carry=0, fifo_count=0, busy=0, done=0, cmd_ready=1.
6. Two back-to-back runs of 3 commands each, so pointers wrap past DEPTH -> commands execute in push order and the second run's acc starts from the first run's final acc.
